// File: rtl/secuencia_rtc.sv
// Sequencer in front of the RTC parallel-bus engine: one init write after reset, periodic
// six-register poll into a holding bank, and a one-deep slot for user writes.
module secuencia_rtc #(
   parameter logic [7:0]  INIT_ADDR = 8'h02,
   parameter logic [7:0]  INIT_DATA = 8'h10,
   parameter logic [7:0]  BASE_ADDR = 8'h21,
   parameter int unsigned REFRESH   = 100000,
   parameter int unsigned TIMEOUT   = 63
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flag_work_s,
   input  logic       tomar_dato,
   input  logic [7:0] data,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       flag_in,
   output logic       lee_escribe_m,
   output logic [7:0] add,
   output logic [7:0] datos,
   output logic [7:0] seg,
   output logic [7:0] min,
   output logic [7:0] hora,
   output logic [7:0] dia,
   output logic [7:0] mes,
   output logic [7:0] anio,
   output logic       datos_validos,
   output logic       wr_ack,
   output logic       ocupado,
   output logic       error
);

   localparam logic [5:0]  TOUT_MAX = 6'(TIMEOUT);
   localparam logic [31:0] REF_LAST = 32'(REFRESH - 1);

   typedef enum logic [2:0] {
      StInit, StLanza, StEspIni, StEspFin, StDecide, StReposo, StFallo
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  add_q, add_d, datos_q, datos_d;
   logic        lee_q, lee_d;
   logic [7:0]  bank_q [6];
   logic [7:0]  bank_d [6];
   logic [7:0]  shadow_q, shadow_d;
   logic [2:0]  idx_q, idx_d;
   logic        sweep_q, sweep_d;
   logic        user_q, user_d;
   logic        pend_q, pend_d;
   logic [7:0]  pend_addr_q, pend_addr_d, pend_data_q, pend_data_d;
   logic [31:0] ref_cnt_q, ref_cnt_d;
   logic [5:0]  tout_q, tout_d;
   logic        error_q, error_d;
   logic        valid_q, valid_d;
   logic        ack_q, ack_d;

   always_comb begin
      state_d     = state_q;
      add_d       = add_q;
      datos_d     = datos_q;
      lee_d       = lee_q;
      bank_d      = bank_q;
      shadow_d    = shadow_q;
      idx_d       = idx_q;
      sweep_d     = sweep_q;
      user_d      = user_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      ref_cnt_d   = ref_cnt_q;
      tout_d      = '0;
      error_d     = error_q;
      valid_d     = 1'b0;
      ack_d       = 1'b0;

      unique case (state_q)
         StInit: begin
            state_d = StLanza;
            add_d   = INIT_ADDR;
            datos_d = INIT_DATA;
            lee_d   = 1'b1;
            user_d  = 1'b0;
         end
         StLanza: state_d = StEspIni;
         StEspIni: begin
            if (flag_work_s)             state_d = StEspFin;
            else if (tout_q == TOUT_MAX) state_d = StFallo;
            else                         tout_d  = tout_q + 6'd1;
         end
         StEspFin: begin
            if (tomar_dato) shadow_d = data;
            if (!flag_work_s) begin
               state_d = StDecide;
               // Reads always commit the shadow, even if tomar_dato never rose.
               if (!lee_q) begin
                  if (idx_q < 3'd6) bank_d[idx_q] = shadow_d;
                  idx_d   = idx_q + 3'd1;
                  valid_d = (idx_q == 3'd5);
               end else if (user_q) begin
                  ack_d = 1'b1;
               end
            end else if (tout_q == TOUT_MAX) begin
               state_d = StFallo;
            end else begin
               tout_d = tout_q + 6'd1;
            end
         end
         StDecide: begin
            if (pend_q) begin
               state_d = StLanza;
               add_d   = pend_addr_q;
               datos_d = pend_data_q;
               lee_d   = 1'b1;
               user_d  = 1'b1;
               pend_d  = 1'b0;
            end else if (sweep_q && idx_q < 3'd6) begin
               state_d = StLanza;
               add_d   = BASE_ADDR + {5'd0, idx_q};
               datos_d = 8'h00;
               lee_d   = 1'b0;
               user_d  = 1'b0;
            end else begin
               state_d   = StReposo;
               sweep_d   = 1'b0;
               ref_cnt_d = '0;
            end
         end
         StReposo: begin
            if (pend_q) begin
               state_d = StDecide;
            end else if (ref_cnt_q == REF_LAST) begin
               state_d = StDecide;
               sweep_d = 1'b1;
               idx_d   = 3'd0;
            end else begin
               ref_cnt_d = ref_cnt_q + 32'd1;
            end
         end
         StFallo: begin
            state_d   = StReposo;
            error_d   = 1'b1;
            sweep_d   = 1'b0;
            ref_cnt_d = '0;
         end
         default: state_d = StInit;
      endcase

      // A request that lands while the slot is full replaces it.
      if (wr_req) begin
         pend_d      = 1'b1;
         pend_addr_d = wr_addr;
         pend_data_d = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StInit;
         add_q       <= '0;
         datos_q     <= '0;
         lee_q       <= 1'b0;
         bank_q      <= '{default: '0};
         shadow_q    <= '0;
         idx_q       <= '0;
         sweep_q     <= 1'b0;
         user_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         ref_cnt_q   <= '0;
         tout_q      <= '0;
         error_q     <= 1'b0;
         valid_q     <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         add_q       <= add_d;
         datos_q     <= datos_d;
         lee_q       <= lee_d;
         bank_q      <= bank_d;
         shadow_q    <= shadow_d;
         idx_q       <= idx_d;
         sweep_q     <= sweep_d;
         user_q      <= user_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         ref_cnt_q   <= ref_cnt_d;
         tout_q      <= tout_d;
         error_q     <= error_d;
         valid_q     <= valid_d;
         ack_q       <= ack_d;
      end
   end

   assign flag_in       = (state_q == StLanza);
   assign ocupado       = (state_q == StLanza) || (state_q == StEspIni) || (state_q == StEspFin);
   assign lee_escribe_m = lee_q;
   assign add           = add_q;
   assign datos         = datos_q;
   assign seg           = bank_q[0];
   assign min           = bank_q[1];
   assign hora          = bank_q[2];
   assign dia           = bank_q[3];
   assign mes           = bank_q[4];
   assign anio          = bank_q[5];
   assign datos_validos = valid_q;
   assign wr_ack        = ack_q;
   assign error         = error_q;

endmodule

// File: tb/tb_secuencia_rtc.sv
// Bench for secuencia_rtc: bus-engine model with a register memory, an expected-transaction
// scoreboard built from a sequence-level reference model, and a decoupled monitor.
module tb_secuencia_rtc;

   localparam int unsigned REFRESH = 30;
   localparam logic [7:0]  BASE    = 8'h21;

   logic       clk = 1'b0;
   logic       reset;
   logic       flag_work_s, tomar_dato;
   logic [7:0] data;
   logic       wr_req;
   logic [7:0] wr_addr, wr_data;
   logic       flag_in, lee_escribe_m;
   logic [7:0] add, datos, seg, min, hora, dia, mes, anio;
   logic       datos_validos, wr_ack, ocupado, error;

   always #5 clk = ~clk;

   secuencia_rtc #(
      .INIT_ADDR (8'h02),
      .INIT_DATA (8'h10),
      .BASE_ADDR (BASE),
      .REFRESH   (REFRESH),
      .TIMEOUT   (63)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flag_work_s   (flag_work_s),
      .tomar_dato    (tomar_dato),
      .data          (data),
      .wr_req        (wr_req),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .flag_in       (flag_in),
      .lee_escribe_m (lee_escribe_m),
      .add           (add),
      .datos         (datos),
      .seg           (seg),
      .min           (min),
      .hora          (hora),
      .dia           (dia),
      .mes           (mes),
      .anio          (anio),
      .datos_validos (datos_validos),
      .wr_ack        (wr_ack),
      .ocupado       (ocupado),
      .error         (error)
   );

   typedef struct packed {
      logic       is_wr;
      logic [7:0] addr;
      logic [7:0] dat;
   } txn_t;

   typedef struct packed {
      logic        is_valid;
      logic [47:0] bank;
   } evt_t;

   txn_t       txn_q[$];
   evt_t       evt_q[$];
   logic [7:0] ref_mem [256];
   logic [7:0] eng_mem [256];
   logic [7:0] bank_exp [6];
   bit         eng_dead = 1'b0;
   int         total = 0;
   int         bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string msg);
      total++;
      bad++;
      $display("FAIL %s", msg);
   endtask

   // Reference model: the memory seen by the engine and the order of bus transactions.
   task automatic push_write(input logic [7:0] wa, input logic [7:0] wd, input bit user);
      txn_q.push_back(txn_t'{is_wr: 1'b1, addr: wa, dat: wd});
      ref_mem[wa] = wd;
      if (user) evt_q.push_back(evt_t'{is_valid: 1'b0, bank: 48'h0});
   endtask

   task automatic push_read(input int i);
      logic [7:0] ra;
      ra = BASE + 8'(i);
      txn_q.push_back(txn_t'{is_wr: 1'b0, addr: ra, dat: 8'h00});
      bank_exp[i] = ref_mem[ra];
      if (i == 5)
         evt_q.push_back(evt_t'{is_valid: 1'b1, bank: {bank_exp[5], bank_exp[4], bank_exp[3],
                                                       bank_exp[2], bank_exp[1], bank_exp[0]}});
   endtask

   // A user write issued during read k is served right after read k.
   task automatic push_sweep(input int k, input bit do_wr, input logic [7:0] wa,
                             input logic [7:0] wd);
      for (int i = 0; i < 6; i++) begin
         push_read(i);
         if (do_wr && i == k) push_write(wa, wd, 1'b1);
      end
   endtask

   // Bus engine: busy one cycle (plus jitter) after a start, read data window near the end.
   task automatic run_engine();
      logic [7:0] ea;
      logic [7:0] ed;
      logic       ew;
      int         dly;
      int         dur;
      int         tw;
      bit         abort;
      ea    = add;
      ed    = datos;
      ew    = lee_escribe_m;
      dly   = int'($urandom_range(0, 3));
      dur   = int'($urandom_range(20, 40));
      tw    = dur - 6;
      abort = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < dly && !abort; i++) begin
         @(posedge clk); #1;
         if (reset) abort = 1'b1;
      end
      if (!abort) flag_work_s = 1'b1;
      for (int i = 0; i < dur && !abort; i++) begin
         @(posedge clk); #1;
         if (reset) begin
            abort = 1'b1;
         end else if (!ew && i >= tw && i < tw + 3) begin
            tomar_dato = 1'b1;
            data       = (i == tw + 2) ? eng_mem[ea] : 8'($urandom);
         end else begin
            tomar_dato = 1'b0;
         end
      end
      flag_work_s = 1'b0;
      tomar_dato  = 1'b0;
      if (!abort && ew) eng_mem[ea] = ed;
   endtask

   initial begin
      flag_work_s = 1'b0;
      tomar_dato  = 1'b0;
      data        = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset && flag_in && !eng_dead) run_engine();
      end
   end

   // Monitor: pops the scoreboard whenever the DUT starts a transaction or pulses an event.
   initial begin
      txn_t        t;
      evt_t        e;
      logic [16:0] held;
      held = '0;
      forever begin
         @(negedge clk);
         if (reset) continue;
         if (flag_in) begin
            chk("start_while_engine_busy", 64'(flag_work_s), 64'(0));
            if (txn_q.size() == 0) begin
               $display("FAIL unexpected_txn: got add=%0h wr=%0b, expected none", add,
                        lee_escribe_m);
               total++;
               bad++;
            end else begin
               t = txn_q.pop_front();
               chk("txn_kind", 64'(lee_escribe_m), 64'(t.is_wr));
               chk("txn_addr", 64'(add), 64'(t.addr));
               if (t.is_wr) chk("txn_data", 64'(datos), 64'(t.dat));
            end
            held = {lee_escribe_m, add, datos};
         end else if (ocupado) begin
            chk("request_hold", 64'({lee_escribe_m, add, datos}), 64'(held));
         end
         if (flag_work_s) chk("ocupado_while_engine_busy", 64'(ocupado), 64'(1));
         if (wr_ack || datos_validos) begin
            if (evt_q.size() == 0) begin
               $display("FAIL unexpected_event: got ack=%0b valid=%0b, expected none", wr_ack,
                        datos_validos);
               total++;
               bad++;
            end else begin
               e = evt_q.pop_front();
               chk("event_kind", 64'(datos_validos), 64'(e.is_valid));
               if (datos_validos)
                  chk("bank", 64'({anio, mes, dia, hora, min, seg}), 64'(e.bank));
            end
         end
      end
   end

   task automatic wait_start(input logic [7:0] wa, input logic ww, input string nm);
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (!reset && flag_in && add == wa && lee_escribe_m == ww) return;
      end
      fail_now({nm, ": timeout waiting for transaction start, got none, expected one"});
   endtask

   task automatic wait_valid(input string nm);
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         if (datos_validos) return;
      end
      fail_now({nm, ": timeout waiting for datos_validos, got none, expected one"});
   endtask

   task automatic pulse_wr(input logic [7:0] wa, input logic [7:0] wd);
      @(posedge clk); #1;
      wr_req  = 1'b1;
      wr_addr = wa;
      wr_data = wd;
      @(posedge clk); #1;
      wr_req  = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_ctl"}, 64'({flag_in, ocupado, lee_escribe_m, datos_validos, wr_ack, error}),
          64'(0));
      chk({nm, "_req"}, 64'({add, datos}), 64'(0));
      chk({nm, "_bank"}, 64'({anio, mes, dia, hora, min, seg}), 64'(0));
   endtask

   initial begin
      int         n;
      int         k;
      bit         dbl;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] d0;
      logic [7:0] tv [6];
      reset   = 1'b1;
      wr_req  = 1'b0;
      wr_addr = 8'h00;
      wr_data = 8'h00;
      tv = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h04, 8'h17};
      for (int i = 0; i < 256; i++) begin
         eng_mem[i] = 8'($urandom);
         ref_mem[i] = eng_mem[i];
      end
      for (int i = 0; i < 6; i++) begin
         eng_mem[BASE + 8'(i)] = tv[i];
         ref_mem[BASE + 8'(i)] = tv[i];
         bank_exp[i] = 8'h00;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset_state");

      // Init write, then the first sweep with known register contents.
      push_write(8'h02, 8'h10, 1'b0);
      push_sweep(0, 1'b0, 8'h00, 8'h00);
      @(posedge clk); #1;
      reset = 1'b0;
      wait_valid("sweep_first");
      chk("seg", 64'(seg), 64'(8'h45));
      chk("min", 64'(min), 64'(8'h30));
      chk("hora", 64'(hora), 64'(8'h12));
      chk("anio", 64'(anio), 64'(8'h17));

      // User write during the read of 0x22.
      push_sweep(1, 1'b1, 8'h22, 8'h59);
      wait_start(8'h22, 1'b0, "mid_write_trigger");
      repeat (2) @(posedge clk);
      pulse_wr(8'h22, 8'h59);
      wait_valid("sweep_mid_write");

      // Two requests while busy: only the later one is carried out.
      push_sweep(1, 1'b1, 8'h23, 8'h02);
      wait_start(8'h22, 1'b0, "double_write_trigger");
      pulse_wr(8'h23, 8'h01);
      @(posedge clk);
      pulse_wr(8'h23, 8'h02);
      wait_valid("sweep_double_write");
      chk("min_after_write", 64'(min), 64'(8'h59));
      chk("hora_after_write", 64'(hora), 64'(8'h02));
      chk("error_before_timeout", 64'(error), 64'(0));

      // Engine never answers: timeout, idle for REFRESH cycles, then a retried sweep.
      eng_dead = 1'b1;
      push_read(0);
      wait_start(BASE, 1'b0, "timeout_trigger");
      n = 0;
      while (!error && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_latency_ok", 64'(n >= 64 && n <= 68), 64'(1));
      eng_dead = 1'b0;
      push_sweep(0, 1'b0, 8'h00, 8'h00);
      n = 0;
      while (!flag_in && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("retry_gap_ok", 64'(n >= int'(REFRESH) && n <= int'(REFRESH) + 4), 64'(1));
      wait_valid("sweep_retry");
      chk("error_sticky", 64'(error), 64'(1));

      // Randomized sweeps with single or overwritten user writes at a random read.
      for (int s = 0; s < 6; s++) begin
         n = 0;
         while (evt_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
         end
         for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            eng_mem[BASE + 8'(i)] = d;
            ref_mem[BASE + 8'(i)] = d;
         end
         k   = int'($urandom_range(0, 5));
         dbl = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 5));
         d   = 8'($urandom);
         d0  = 8'($urandom);
         push_sweep(k, 1'b1, a, d);
         wait_start(BASE + 8'(k), 1'b0, "random_trigger");
         repeat ($urandom_range(1, 4)) @(posedge clk);
         if (dbl) pulse_wr(a, d0);
         pulse_wr(a, d);
         wait_valid("sweep_random");
      end

      // Reset in the middle of a read, then INIT must run again.
      n = 0;
      while (evt_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      push_sweep(0, 1'b0, 8'h00, 8'h00);
      wait_start(BASE + 8'd2, 1'b0, "reset_trigger");
      n = 0;
      while (!flag_work_s && n < 10) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      txn_q.delete();
      evt_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset_mid_read");
      for (int i = 0; i < 6; i++) bank_exp[i] = 8'h00;
      push_write(8'h02, 8'h10, 1'b0);
      push_sweep(0, 1'b0, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      wait_valid("sweep_after_reset");
      chk("error_cleared_by_reset", 64'(error), 64'(0));
      chk("txn_left", 64'(txn_q.size()), 64'(0));
      chk("evt_left", 64'(evt_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
